// File: rtl/lifo_register_if.sv
// Control/status bundle between a stack controller (master) and lifo_register (slave).
// Zero latency: status fields reflect stored state; no handshake, no backpressure.
// Controller must consult full/empty itself to avoid raising ovf/udf.
interface lifo_register_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
);
    logic                     push;
    logic                     pop;
    logic                     clr_err;
    logic [WIDTH-1:0]         d;
    logic [WIDTH-1:0]         q;
    logic [$clog2(DEPTH):0]   count;
    logic                     empty;
    logic                     full;
    logic                     ovf;
    logic                     udf;

    modport master (
        output push, pop, clr_err, d,
        input  q, count, empty, full, ovf, udf
    );

    modport slave (
        input  push, pop, clr_err, d,
        output q, count, empty, full, ovf, udf
    );
endinterface

// File: rtl/lifo_register.sv
// LIFO register stack (return-address / operand stack) with push, pop and replace-top.
// Latency: zero cycles from state; an operation sampled at edge N is visible right after edge N.
// No backpressure: illegal push/pop is dropped and recorded in sticky ovf/udf flags.
module lifo_register #(
    parameter int               WIDTH   = 12,
    parameter int               DEPTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    lifo_register_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             is_empty;
    logic             is_full;
    logic [AW-1:0]    top_idx;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == CW'(DEPTH));
    // At sp==DEPTH the low index bits are zero, so the wrap yields DEPTH-1.
    assign top_idx  = sp_q[AW-1:0] - AW'(1);

    always_comb begin
        sp_d   = sp_q;
        wr_en  = 1'b0;
        wr_idx = '0;
        ovf_d  = bus.clr_err ? 1'b0 : ovf_q;
        udf_d  = bus.clr_err ? 1'b0 : udf_q;

        case ({bus.push, bus.pop})
            2'b10: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en  = 1'b1;
                    wr_idx = sp_q[AW-1:0];
                    sp_d   = sp_q + CW'(1);
                end
            end
            2'b01: begin
                if (is_empty) begin
                    udf_d = 1'b1;
                end else begin
                    sp_d = sp_q - CW'(1);
                end
            end
            2'b11: begin
                wr_en = 1'b1;
                if (is_empty) begin
                    // Nothing to replace: the push still happens but the pop is an underflow.
                    wr_idx = '0;
                    sp_d   = CW'(1);
                    udf_d  = 1'b1;
                end else begin
                    wr_idx = top_idx;
                end
            end
            default: begin
                sp_d = sp_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            if (wr_en) begin
                mem_q[wr_idx] <= bus.d;
            end
        end
    end

    assign bus.q     = is_empty ? RST_VAL : mem_q[top_idx];
    assign bus.count = sp_q;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;
endmodule

// File: doc/lifo_register.md
# lifo_register

Parametrised LIFO register stack: the depth-and-mode generalisation of the single load-enabled register, holding up to DEPTH words of WIDTH bits with push, pop and replace-top operations. It sits beside the program counter register and serves as the hardware return-address stack for call/return instructions. It can also be instantiated at 8-bit width as an operand stack. Top-of-stack is always visible combinationally from state. Occupancy, full/empty and sticky overflow/underflow flags are exported to the controller.

## Interface
- WIDTH, 12, data word width in bits (≥1).
- DEPTH, 8, number of entries; power of two, ≥2.
- RST_VAL, 0, value loaded into every entry on reset and driven on q when empty.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 clears state immediately, independent of clk.
- push  input  1  push d onto the stack at the next rising edge.
- pop  input  1  remove the top entry at the next rising edge.
- d  input  WIDTH  data to push.
- clr_err  input  1  synchronous clear of ovf/udf.
- q  output  WIDTH  current top entry; RST_VAL when empty.
- count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- ovf  output  1  sticky: push attempted while full, without pop.
- udf  output  1  sticky: pop attempted while empty.

## Operation
- Storage is DEPTH registers mem[0..DEPTH-1] plus occupancy counter sp (=count). mem[sp-1] is the top entry.
- Per rising edge, with rst=1:
  - push=0, pop=0: hold.
  - push=1, pop=0, not full: mem[sp]<=d, sp<=sp+1.
  - push=1, pop=0, full: no change to storage or sp; ovf<=1.
  - push=0, pop=1, not empty: sp<=sp-1. Popped entry content is not required to clear.
  - push=0, pop=1, empty: no change; udf<=1.
  - push=1, pop=1, not empty (including full): replace top, mem[sp-1]<=d, sp unchanged, no flag set.
  - push=1, pop=1, empty: push performed (mem[0]<=d, sp<=1); udf<=1.
- Error flags:
  - clr_err=1 clears ovf and udf at the edge.
  - If a new error event occurs on the same edge, that flag is set (set wins over clear).
- Arithmetic:
  - sp never exceeds DEPTH and never wraps below 0.
  - The counter is one bit wider than the index, so full and empty are distinct.
- Derived outputs:
  - q = empty ? RST_VAL : mem[sp-1].
  - empty, full and count are decoded combinationally from sp only.
- Reset (rst=0): all mem entries <= RST_VAL, sp<=0, ovf<=0, udf<=0.

## Timing
- Reset values:
  - q=RST_VAL, count=0, empty=1, full=0, ovf=0, udf=0.
  - Outputs take these values as soon as rst falls; no clock is required.
  - Reset asserted mid-operation discards all contents and any same-cycle push/pop.
- Reset deassertion:
  - The first edge at which rst=1 is sampled may perform an operation.
  - rst must meet recovery time relative to clk.
- Latency: zero cycles from state.
  - A push sampled at edge N makes q=d, count+1 visible after edge N.
  - A pop at edge N exposes the next entry after edge N.
- Control inputs are sampled only at the rising edge; no handshake and no stall. The controller must check full/empty if it needs to avoid flag setting.
- Flags assert the cycle after the offending edge and hold until clr_err or reset.

## Test plan
- Reset: drive rst=0 mid-cycle with push=1 -> q=0, count=0, empty=1, full=0, ovf=udf=0 immediately; after rst=1, count stays 0 with idle inputs.
- Fill/drain (WIDTH=12, DEPTH=8): push 0x101..0x108 on 8 edges -> full=1, count=8, q=0x108; 8 pops -> q steps 0x107..0x101, then RST_VAL, empty=1; no flags.
- Overflow: from full, push 0xABC -> count stays 8, q=0x108, ovf=1; push+pop 0xABC while full -> q=0xABC, count=8, ovf still 1; clr_err -> ovf=0.
- Underflow: pop while empty -> udf=1, count=0; push+pop with d=0x055 while empty -> count=1, q=0x055, udf=1.
- Replace-top: with entries 0x010, 0x020, push+pop d=0x030 -> count=2, q=0x030; pop -> q=0x010.
- Set-wins/params: clr_err=1 with pop on empty -> udf remains 1. Repeat the fill/drain test with WIDTH=8, DEPTH=4, RST_VAL=8'hFF -> count width 3, q=0xFF when empty.
